reg8_access_arbiter: RTL
========================

Name: reg8_access_arbiter

Overview:
- Shares one 8-bit data register between two requesters with round-robin arbitration.
- The register is held internally and is updated only through this block.
- Each granted request performs one operation on the register: load, shift left logical, shift right logical, or shift right arithmetic.
- Sits in front of the shifter/register datapath. The read value is continuously visible to all clients.

Parameters:
RESET_VAL, 8'h00, value of the register after reset.

Ports:
clk  input  1  system clock; all state updates on its rising edge
reset  input  1  synchronous active-high reset
req0  input  1  requester 0 request (level)
op0  input  2  requester 0 operation: 00 load, 01 SLL, 10 SRL, 11 SRA
din0  input  8  requester 0 data: load value, or shift amount in bits [2:0]
req1  input  1  requester 1 request (level)
op1  input  2  requester 1 operation, same encoding as op0
din1  input  8  requester 1 data, same meaning as din0
gnt  output  2  one-hot grant, high during the EXEC state
ack  output  2  one-hot completion pulse, one cycle, high during the DONE state
busy  output  1  high whenever the FSM is not in IDLE
q  output  8  current register value

Behaviour:
- Reset: single clock, synchronous, active-high. Asserting reset at a rising edge of clk gives the following, regardless of state, including mid-operation:
  - state=IDLE, q=RESET_VAL, gnt=0, ack=0, busy=0.
  - Priority pointer set to requester 0.
  - Any in-flight operation is discarded and no ack is issued.
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - If any req is high, pick a winner and go to EXEC. Otherwise stay in IDLE.
  - Winner selection: only one req high, that requester wins. Both high, the requester named by the priority pointer wins.
  - At the IDLE->EXEC edge, latch the winner's op, din and index into internal registers.
- EXEC:
  - gnt[winner]=1, busy=1.
  - At the EXEC->DONE edge, q <= f(q, latched op, latched din).
- DONE:
  - ack[winner]=1, busy=1. q already shows the new value.
  - Priority pointer <= the other requester.
  - Next state is IDLE unconditionally.
- Operation f:
  - load: q <= din.
  - SLL: q <= q << din[2:0], zero fill.
  - SRL: q <= q >> din[2:0], zero fill.
  - SRA: q <= q >>> din[2:0], fill with q[7].
  - Shift amount 0 leaves q unchanged but still completes with an ack.
  - din[7:3] are ignored for shift ops.
- Latency and throughput:
  - A request sampled in IDLE at cycle N gives gnt at N+1, ack and the new q at N+2, and IDLE again at N+3.
  - Maximum rate is one operation per 3 cycles.
- Request rules:
  - req is sampled only in IDLE. Changes to req, op or din during EXEC/DONE have no effect on the operation in flight.
  - A req still high in the IDLE cycle after its ack counts as a new request.
  - With both requesters holding req, grants strictly alternate 0,1,0,1...
  - A requester that drops req before being sampled in IDLE is never served.
- Outputs:
  - gnt and ack are registered-state decodes: mutually exclusive, never both high, at most one bit set each.
  - q changes only at the EXEC->DONE edge or on reset.

Test Plan:
- Reset: hold reset for 2 cycles with req0=1 -> q=8'h00, gnt=0, ack=0, busy=0. After release, the first grant goes to requester 0 in the cycle after the first IDLE sample.
- Single load: req0 with op0=00, din0=8'hA5 for one IDLE cycle -> gnt=2'b01 at +1; ack=2'b01 and q=8'hA5 at +2; busy low at +3.
- Shifts: from q=8'h96, req1 with op=11 (SRA), din=3 -> q=8'hF2. Then SRL by 3 -> q=8'h1E. Then SLL by 4 -> q=8'hE0. Then SLL by 0 -> q unchanged with an ack.
- Round-robin: req0 and req1 held high continuously, loads of 8'h11 and 8'h22 -> grants alternate 01,10,01,10 every 3 cycles, q alternates 8'h11/8'h22, and no two acks in the same cycle.
- Ignored mid-op changes: change din0 and op0, and raise req1, during EXEC -> latched op completes with the original values; req1 is served next.
- Reset mid-operation: assert reset in the EXEC cycle of a load of 8'h3C from q=8'h55 -> q=RESET_VAL, no ack pulse, pointer back to requester 0.

Source files
------------

// File: rtl/reg8_access_arbiter.sv
// rtl/reg8_access_arbiter.sv - two-requester round-robin arbiter in front of an 8-bit load/shift register
module reg8_access_arbiter #(
    parameter logic [7:0] RESET_VAL = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic [1:0] op0,
    input  logic [7:0] din0,
    input  logic       req1,
    input  logic [1:0] op1,
    input  logic [7:0] din1,
    output logic [1:0] gnt,
    output logic [1:0] ack,
    output logic       busy,
    output logic [7:0] q
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_SLL  = 2'b01;
    localparam logic [1:0] OP_SRL  = 2'b10;
    localparam logic [1:0] OP_SRA  = 2'b11;

    state_t     r_state;
    state_t     w_next_state;

    // r_ptr names the requester that wins when both ask at once.
    logic       r_ptr;
    logic       r_idx;
    logic [1:0] r_op;
    logic [7:0] r_din;
    logic [7:0] r_q;

    logic       w_any_req;
    logic       w_win_idx;
    logic [1:0] w_win_op;
    logic [7:0] w_win_din;
    logic [2:0] w_amt;
    logic [7:0] w_result;
    logic [1:0] w_gnt;
    logic [1:0] w_ack;
    logic       w_busy;

    // Winner selection from the live request lines; only consumed in IDLE.
    always_comb begin
        w_any_req = req0 | req1;
        w_win_idx = 1'b0;
        if (req0 && req1) begin
            w_win_idx = r_ptr;
        end else if (req1) begin
            w_win_idx = 1'b1;
        end
        w_win_op  = w_win_idx ? op1  : op0;
        w_win_din = w_win_idx ? din1 : din0;
    end

    // Operation on the register using only the latched op/data, so inputs may change freely mid-op.
    always_comb begin
        w_amt    = r_din[2:0];
        w_result = r_q;
        case (r_op)
            OP_LOAD: w_result = r_din;
            OP_SLL:  w_result = r_q << w_amt;
            OP_SRL:  w_result = r_q >> w_amt;
            OP_SRA:  w_result = 8'($signed(r_q) >>> w_amt);
            default: w_result = r_q;
        endcase
    end

    // Next-state and output decode; gnt/ack depend only on state and the latched index.
    always_comb begin
        w_next_state = r_state;
        w_gnt        = 2'b00;
        w_ack        = 2'b00;
        w_busy       = 1'b1;
        case (r_state)
            ST_IDLE: begin
                w_busy = 1'b0;
                if (w_any_req) begin
                    w_next_state = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_gnt        = r_idx ? 2'b10 : 2'b01;
                w_next_state = ST_DONE;
            end
            ST_DONE: begin
                w_ack        = r_idx ? 2'b10 : 2'b01;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State register, request latch, register update and pointer rotation.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_ptr   <= 1'b0;
            r_idx   <= 1'b0;
            r_op    <= OP_LOAD;
            r_din   <= 8'h00;
            r_q     <= RESET_VAL;
        end else begin
            r_state <= w_next_state;
            if (r_state == ST_IDLE && w_any_req) begin
                r_idx <= w_win_idx;
                r_op  <= w_win_op;
                r_din <= w_win_din;
            end
            if (r_state == ST_EXEC) begin
                r_q <= w_result;
            end
            if (r_state == ST_DONE) begin
                r_ptr <= ~r_idx;
            end
        end
    end

    assign gnt  = w_gnt;
    assign ack  = w_ack;
    assign busy = w_busy;
    assign q    = r_q;

endmodule
